// File: rtl/led_scan_sequencer_if.sv
// Panel-side signal bundle for led_scan_sequencer.
// master: the sequencer (drives timing/address outputs, samples enable).
// slave : the consumer side (frame buffer, PWM comparator, panel driver).
//   enable      run request into the sequencer
//   pwmlvl      PWM compare level for the row being shifted
//   col_addr    frame-buffer column address
//   shift_row   frame-buffer row address (row being shifted)
//   row_addr    panel row-select lines (row being displayed)
//   sclk        panel shift clock
//   latch       panel latch strobe
//   oe_n        panel output enable, active low
//   frame_done  1-cycle pulse at end of each full frame
interface led_scan_sequencer_if #(
  parameter int unsigned PWM_WIDTH = 12,
  parameter int unsigned COL_BITS  = 5,
  parameter int unsigned ROW_BITS  = 4
);
  logic                 enable;
  logic [PWM_WIDTH-1:0] pwmlvl;
  logic [COL_BITS-1:0]  col_addr;
  logic [ROW_BITS-1:0]  shift_row;
  logic [ROW_BITS-1:0]  row_addr;
  logic                 sclk;
  logic                 latch;
  logic                 oe_n;
  logic                 frame_done;

  modport master (
    input  enable,
    output pwmlvl, col_addr, shift_row, row_addr, sclk, latch, oe_n, frame_done
  );

  modport slave (
    output enable,
    input  pwmlvl, col_addr, shift_row, row_addr, sclk, latch, oe_n, frame_done
  );
endinterface

// File: rtl/led_scan_sequencer.sv
// HUB75-style LED panel timing master. Shifts one row per PWM level step
// (3 cycles per column: address, settle, shift clock), then blanks, latches
// and advances the row; the level counter advances when the row counter wraps.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    led_scan_sequencer_if.master (enable in; panel/frame-buffer outputs)
// Build option:
//   PWMLVL_BITREV_EN  pwmlvl is the bit-reversed level counter; counter,
//                     wrap and frame_done timing are unaffected.
module led_scan_sequencer #(
  parameter int unsigned PWM_WIDTH    = 12,
  parameter int unsigned COL_BITS     = 5,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  led_scan_sequencer_if.master bus
);

  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StBlank, StLatch} state_e;

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [BlankW-1:0]    blank_q, blank_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ROW_BITS-1:0]  shift_row_q, shift_row_d;
  logic [ROW_BITS-1:0]  row_addr_q, row_addr_d;
  logic [PWM_WIDTH-1:0] level_q, level_d;
  // Set by the first latch; until then the panel holds no valid row.
  logic                 lit_q, lit_d;
  logic                 sclk_q, sclk_d;
  logic                 latch_q, latch_d;
  logic                 oe_n_q, oe_n_d;
  logic                 frame_done_q, frame_done_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    blank_d     = blank_q;
    col_d       = col_q;
    shift_row_d = shift_row_q;
    row_addr_d  = row_addr_q;
    level_d     = level_q;
    lit_d       = lit_q;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d = StShift;
          phase_d = 2'd0;
        end
      end
      StShift: begin
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          // Wraps to 0 after the last column, leaving col_addr at 0 for idle.
          col_d   = col_q + 1'b1;
          if (col_q == '1) begin
            state_d = StBlank;
            blank_d = '0;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StBlank: begin
        if (blank_q == BlankW'(BLANK_CYCLES - 1)) begin
          state_d = StLatch;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      StLatch: begin
        row_addr_d  = shift_row_q;
        shift_row_d = shift_row_q + 1'b1;
        if (shift_row_q == '1) begin
          level_d = level_q + 1'b1;
        end
        lit_d   = 1'b1;
        phase_d = 2'd0;
        state_d = bus.enable ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs follow the state being entered.
    sclk_d       = (state_d == StShift) && (phase_d == 2'd2);
    latch_d      = (state_d == StLatch);
    oe_n_d       = !((state_d == StShift) && lit_d);
    frame_done_d = (state_d == StLatch) && (state_q != StLatch) &&
                   (shift_row_q == '1) && (level_q == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= 2'd0;
      blank_q      <= '0;
      col_q        <= '0;
      shift_row_q  <= '0;
      row_addr_q   <= '0;
      level_q      <= '0;
      lit_q        <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      blank_q      <= blank_d;
      col_q        <= col_d;
      shift_row_q  <= shift_row_d;
      row_addr_q   <= row_addr_d;
      level_q      <= level_d;
      lit_q        <= lit_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PWMLVL_BITREV_EN
  for (genvar i = 0; i < PWM_WIDTH; i++) begin : g_bitrev
    assign bus.pwmlvl[i] = level_q[PWM_WIDTH-1-i];
  end
`else
  assign bus.pwmlvl = level_q;
`endif

  assign bus.col_addr   = col_q;
  assign bus.shift_row  = shift_row_q;
  assign bus.row_addr   = row_addr_q;
  assign bus.sclk       = sclk_q;
  assign bus.latch      = latch_q;
  assign bus.oe_n       = oe_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Self-checking bench for led_scan_sequencer with COLS=4, ROWS=2, 2-bit PWM,
// 2 blank cycles (row period 15). Outputs sampled on the falling edge.
module tb_led_scan_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  led_scan_sequencer_if #(.PWM_WIDTH(2), .COL_BITS(2), .ROW_BITS(1)) bus ();

  led_scan_sequencer #(
    .PWM_WIDTH   (2),
    .COL_BITS    (2),
    .ROW_BITS    (1),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // One row, cycle by cycle from the first SHIFT cycle; oe_n is the value
  // once the panel has been latched at least once.
  typedef struct {
    logic       en;
    logic       sclk;
    logic       latch;
    logic       oe_n;
    logic [1:0] col;
  } vec_t;

  vec_t row_tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_lvl(input int lvl);
    logic [1:0] l;
    l = 2'(lvl);
`ifdef PWMLVL_BITREV_EN
    return {l[0], l[1]};
`else
    return l;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " sclk"},       32'(bus.sclk), 32'd0);
    check({tag, " latch"},      32'(bus.latch), 32'd0);
    check({tag, " oe_n"},       32'(bus.oe_n), 32'd1);
    check({tag, " col_addr"},   32'(bus.col_addr), 32'd0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    //              en    sclk  latch oe_n  col
    row_tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    row_tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    row_tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    row_tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    row_tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    row_tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    row_tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    row_tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    row_tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    row_tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    row_tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    row_tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
    row_tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    row_tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    row_tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0};

    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state, still idle with enable low.
    check_idle_outputs("reset");
    check("reset pwmlvl",    32'(bus.pwmlvl), 32'd0);
    check("reset shift_row", 32'(bus.shift_row), 32'd0);
    check("reset row_addr",  32'(bus.row_addr), 32'd0);

    // Eight rows = one full frame.
    bus.enable = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        bus.enable = row_tbl[k].en;
        check($sformatf("r%0d k%0d sclk", r, k),  32'(bus.sclk),  32'(row_tbl[k].sclk));
        check($sformatf("r%0d k%0d latch", r, k), 32'(bus.latch), 32'(row_tbl[k].latch));
        check($sformatf("r%0d k%0d col", r, k),   32'(bus.col_addr), 32'(row_tbl[k].col));
        check($sformatf("r%0d k%0d oe_n", r, k),  32'(bus.oe_n),
              32'((r == 0 && k < 12) ? 1'b1 : row_tbl[k].oe_n));
        check($sformatf("r%0d k%0d shift_row", r, k), 32'(bus.shift_row), 32'(r % 2));
        check($sformatf("r%0d k%0d row_addr", r, k), 32'(bus.row_addr),
              32'((r == 0) ? 0 : (r - 1) % 2));
        check($sformatf("r%0d k%0d pwmlvl", r, k), 32'(bus.pwmlvl), 32'(exp_lvl(r / 2)));
        check($sformatf("r%0d k%0d frame_done", r, k), 32'(bus.frame_done),
              32'((r == 7 && k == 14) ? 1 : 0));
      end
    end

    // First cycle of the next frame: level wrapped, row_addr shows row 1.
    @(negedge clk);
    check("wrap pwmlvl",    32'(bus.pwmlvl), 32'd0);
    check("wrap shift_row", 32'(bus.shift_row), 32'd0);
    check("wrap row_addr",  32'(bus.row_addr), 32'd1);
    check("wrap oe_n",      32'(bus.oe_n), 32'd0);
    check("wrap frame_done", 32'(bus.frame_done), 32'd0);

    // Drop enable at column 1; row must still complete and latch.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("stop col1", 32'(bus.col_addr), 32'd1);
    bus.enable = 1'b0;
    for (int k = 4; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("stop k%0d sclk", k),  32'(bus.sclk),  32'(row_tbl[k].sclk));
      check($sformatf("stop k%0d latch", k), 32'(bus.latch), 32'(row_tbl[k].latch));
      check($sformatf("stop k%0d col", k),   32'(bus.col_addr), 32'(row_tbl[k].col));
    end
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("idle");
      check("idle shift_row", 32'(bus.shift_row), 32'd1);
      check("idle row_addr",  32'(bus.row_addr), 32'd0);
    end

    // Resume: next row shifts with the panel lit.
    bus.enable = 1'b1;
    @(negedge clk);
    check("resume oe_n",      32'(bus.oe_n), 32'd0);
    check("resume col",       32'(bus.col_addr), 32'd0);
    check("resume shift_row", 32'(bus.shift_row), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("resume sclk", 32'(bus.sclk), 32'd1);

    // Asynchronous reset mid-SHIFT: outputs return at once.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("async rst");
    check("async rst pwmlvl",    32'(bus.pwmlvl), 32'd0);
    check("async rst shift_row", 32'(bus.shift_row), 32'd0);
    check("async rst row_addr",  32'(bus.row_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
